instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and emit queue for the 5-bit-opcode processor, the inverse of the control decoder. It takes one decoded operation per handshake (class, math function, immediate flag, register fields, immediate), builds the opcode and the 32-bit instruction word, and queues the result in a 2-entry buffer. Each word leaves on a valid/ready stream with a wrapping instruction-memory address, for use by the program loader or by a self-test generator.

## Interface
- AW, 8, instruction-memory address width; the address wraps at 2^AW.
- BASE, 0, first address after reset and after `restart`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation present.
- in_ready  out  1  encoder accepts the operation this cycle.
- in_is_math  in  1  1 = math op, selected by `in_func`; 0 = control op, selected by `in_class`.
- in_imm  in  1  immediate form of a math op.
- in_func  in  3  0 add, 1 sub, 2 mult, 3 div, 4 and, 5 or, 6 xor, 7 illegal.
- in_class  in  3  0 bgt, 1 slt, 2 lw, 3 sw, 4 beq, 5 bne, 6 jr, 7 j.
- in_rd, in_rs, in_rt  in  5 each  register fields.
- in_imm_val  in  17  immediate / jump target.
- restart  in  1  single-cycle pulse; reloads the address counter to BASE.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- out_word  out  32  encoded instruction.
- out_addr  out  AW  address for `out_word`.
- err  out  1  sticky illegal-operation flag.
- err_clr  in  1  clears `err`.

## Operation
- Opcode for math ops with func 0..3: {0, in_imm, 1, func[1:0]}.
  - Examples: add 00100, subi 01101.
- Opcode for math ops with func 4..6: {0, in_imm, 0, (func−3)[1:0]}.
  - Examples: and 00001, ori 01010.
- Opcode for control ops: {1, 0, class[2:0]}.
  - Examples: bgt 10000, j 10111.
- Word layout:
  - opcode at [31:27].
  - Register/immediate ops: in_rd at [26:22], in_rs at [21:17].
  - Register ops (math with in_imm=0, and slt): in_rt at [16:12], [11:0]=0.
  - Immediate ops (math with in_imm=1, lw, sw, bgt, beq, bne): in_imm_val at [16:0].
  - jr: in_rs at [21:17]; all other bits 0.
  - j: in_imm_val at [16:0], [26:17]=0.
- Illegal operations: func 7, or xor with in_imm=1.
  - The operation is accepted, not queued, and sets `err`.
  - The address does not advance.
- Buffer: 2-entry FIFO, count 0..2.
  - in_ready = (count<2) or (count==2 and out_ready).
  - out_valid = count>0.
  - Output comes from the head entry.
- Address counter:
  - Assigned when a word enters the buffer; increments by 1 per legal accepted op, wrapping modulo 2^AW.
  - `restart` sets the counter to BASE.
  - A push in the same cycle as `restart` gets address BASE, and the counter becomes BASE+1.
- err_clr takes priority over setting `err` when both occur in the same cycle.

## Timing
- Reset values:
  - count=0, out_valid=0, in_ready=1, out_word=0, out_addr=0, err=0.
  - address counter = BASE.
- Latency: a word accepted in cycle N is presented on out_valid in cycle N+1 when the buffer was empty.
- Throughput: 1 word/cycle with out_ready held high.
- A simultaneous push and pop with count=2 is allowed; count stays 2.
- out_word/out_addr hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all buffered words are discarded immediately (asynchronous reset). No output pulse follows reset.

## Configuration
- INSTR_ENC_ERR_CHECK_EN:
  - Defined: illegal detection and the `err` behaviour are as above.
  - Undefined: `err` is tied to 0, illegal ops are queued with opcode 00000 (nop), and the address advances.

## Structure
- Shared package holds:
  - opcode localparams (all 21 codes);
  - func and class enums;
  - field bit positions;
  - the word-layout enum (R, I, JR, J).
- One sub-module, `instr_field_pack`: combinational opcode build, layout select and illegal detect.
- Buffer and address counter live in the top module.

## Test plan
- addi (in_is_math=1, in_imm=1, func 0), rd=3, rs=1, imm=5, from reset -> out_word 0x60C20005, out_addr BASE, out_valid on the next cycle.
- xor (func 6, in_imm=0), rd=2, rs=4, rt=6 -> out_word 0x18886000.
- Three back-to-back ops with out_ready=0 -> in_ready drops after 2 accepts. Release out_ready -> words emerge in order with consecutive addresses.
- AW=2: push 5 legal ops -> addresses 0,1,2,3,0. A `restart` pulse between ops 2 and 3 -> op 3 gets BASE.
- func 7 -> err=1, no output, address unchanged. err_clr -> err=0. Repeat with the macro undefined -> word 0x00000000 is emitted.
- Assert rst with 2 words buffered -> out_valid=0 in the same cycle, and the address counter returns to BASE.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, operation enums,
// word field positions and the word-layout selector.
package instr_encoder_pkg;

  localparam int REG_W   = 5;
  localparam int IMM_W   = 17;
  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 22;
  localparam int RS_LSB  = 17;
  localparam int RT_LSB  = 12;
  localparam int IMM_LSB = 0;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_AND   = 5'b00001;
  localparam logic [4:0] OP_OR    = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00101;
  localparam logic [4:0] OP_MULT  = 5'b00110;
  localparam logic [4:0] OP_DIV   = 5'b00111;
  localparam logic [4:0] OP_ANDI  = 5'b01001;
  localparam logic [4:0] OP_ORI   = 5'b01010;
  localparam logic [4:0] OP_ADDI  = 5'b01100;
  localparam logic [4:0] OP_SUBI  = 5'b01101;
  localparam logic [4:0] OP_MULTI = 5'b01110;
  localparam logic [4:0] OP_DIVI  = 5'b01111;
  localparam logic [4:0] OP_BGT   = 5'b10000;
  localparam logic [4:0] OP_SLT   = 5'b10001;
  localparam logic [4:0] OP_LW    = 5'b10010;
  localparam logic [4:0] OP_SW    = 5'b10011;
  localparam logic [4:0] OP_BEQ   = 5'b10100;
  localparam logic [4:0] OP_BNE   = 5'b10101;
  localparam logic [4:0] OP_JR    = 5'b10110;
  localparam logic [4:0] OP_J     = 5'b10111;

  typedef enum logic [2:0] {
    FUNC_ADD, FUNC_SUB, FUNC_MULT, FUNC_DIV, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_ILL
  } func_e;

  typedef enum logic [2:0] {
    CLS_BGT, CLS_SLT, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_JR, CLS_J
  } class_e;

  typedef enum logic [1:0] {LAY_R, LAY_I, LAY_JR, LAY_J} layout_e;

  function automatic logic [4:0] math_opcode(input logic imm, input logic [2:0] func);
    case ({imm, func})
      4'b0000: return OP_ADD;
      4'b0001: return OP_SUB;
      4'b0010: return OP_MULT;
      4'b0011: return OP_DIV;
      4'b0100: return OP_AND;
      4'b0101: return OP_OR;
      4'b0110: return OP_XOR;
      4'b1000: return OP_ADDI;
      4'b1001: return OP_SUBI;
      4'b1010: return OP_MULTI;
      4'b1011: return OP_DIVI;
      4'b1100: return OP_ANDI;
      4'b1101: return OP_ORI;
      default: return OP_NOP;
    endcase
  endfunction

  function automatic logic [4:0] ctrl_opcode(input logic [2:0] cls);
    case (cls)
      3'd0:    return OP_BGT;
      3'd1:    return OP_SLT;
      3'd2:    return OP_LW;
      3'd3:    return OP_SW;
      3'd4:    return OP_BEQ;
      3'd5:    return OP_BNE;
      3'd6:    return OP_JR;
      default: return OP_J;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational opcode build, word-layout select and illegal-operation detect.
// Illegal operations always produce an all-zero word.
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic             is_math,
  input  logic             imm,
  input  logic [2:0]       func,
  input  logic [2:0]       cls,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [IMM_W-1:0] imm_val,
  output logic [31:0]      word,
  output logic             illegal
);

  logic [4:0] opcode;
  layout_e    layout;

  assign illegal = is_math && ((func == FUNC_ILL) || ((func == FUNC_XOR) && imm));

  always_comb begin
    opcode = OP_NOP;
    layout = LAY_R;
    if (is_math) begin
      opcode = math_opcode(imm, func);
      layout = imm ? LAY_I : LAY_R;
    end else begin
      opcode = ctrl_opcode(cls);
      case (cls)
        CLS_SLT: layout = LAY_R;
        CLS_JR:  layout = LAY_JR;
        CLS_J:   layout = LAY_J;
        default: layout = LAY_I;
      endcase
    end
  end

  always_comb begin
    word = '0;
    word[OPC_LSB +: 5] = opcode;
    case (layout)
      LAY_R: begin
        word[RD_LSB +: REG_W] = rd;
        word[RS_LSB +: REG_W] = rs;
        word[RT_LSB +: REG_W] = rt;
      end
      LAY_I: begin
        word[RD_LSB +: REG_W]  = rd;
        word[RS_LSB +: REG_W]  = rs;
        word[IMM_LSB +: IMM_W] = imm_val;
      end
      LAY_JR:  word[RS_LSB +: REG_W] = rs;
      default: word[IMM_LSB +: IMM_W] = imm_val;
    endcase
    if (illegal) word = '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder with a 2-entry emit FIFO and wrapping address counter.
// Define INSTR_ENC_ERR_CHECK_EN to drop illegal ops and flag them on err.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_math,
  input  logic             in_imm,
  input  logic [2:0]       in_func,
  input  logic [2:0]       in_class,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs,
  input  logic [REG_W-1:0] in_rt,
  input  logic [IMM_W-1:0] in_imm_val,
  input  logic             restart,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [AW-1:0]    out_addr,
  output logic             err,
  input  logic             err_clr
);

  logic [31:0]   packed_word;
  logic          illegal;
  logic [31:0]   word_q [2];
  logic [AW-1:0] addr_q [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] base_addr, push_addr;
  logic          accept, push, pop;

  instr_field_pack u_pack (
    .is_math (in_is_math),
    .imm     (in_imm),
    .func    (in_func),
    .cls     (in_class),
    .rd      (in_rd),
    .rs      (in_rs),
    .rt      (in_rt),
    .imm_val (in_imm_val),
    .word    (packed_word),
    .illegal (illegal)
  );

  assign base_addr = AW'(BASE);
  assign in_ready  = (count != 2'd2) || out_ready;
  assign accept    = in_valid && in_ready;
  assign pop       = (count != 2'd0) && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_word  = word_q[rd_ptr];
  assign out_addr  = addr_q[rd_ptr];
  // A push coinciding with restart takes BASE itself.
  assign push_addr = restart ? base_addr : addr_cnt;

`ifdef INSTR_ENC_ERR_CHECK_EN
  assign push = accept && !illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err <= 1'b0;
    else if (err_clr)           err <= 1'b0;
    else if (accept && illegal) err <= 1'b1;
  end
`else
  logic unused_sig;
  assign unused_sig = ^{err_clr, illegal};
  assign push       = accept;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q[0] <= '0;
      word_q[1] <= '0;
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      addr_cnt  <= base_addr;
    end else begin
      if (push) begin
        word_q[wr_ptr] <= packed_word;
        addr_q[wr_ptr] <= push_addr;
        wr_ptr         <= ~wr_ptr;
        addr_cnt       <= push_addr + 1'b1;
      end else if (restart) begin
        addr_cnt <= base_addr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (AW=2, BASE=0): stimulus pushes expected
// {word, addr} pairs; a negedge monitor pops and compares on each output handshake.
module tb_instr_encoder;

  localparam int AW = 2;
`ifdef INSTR_ENC_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic          in_is_math = 1'b0, in_imm = 1'b0;
  logic [2:0]    in_func = '0, in_class = '0;
  logic [4:0]    in_rd = '0, in_rs = '0, in_rt = '0;
  logic [16:0]   in_imm_val = '0;
  logic          restart = 1'b0;
  logic          out_valid, out_ready = 1'b1;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          err, err_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] model_addr = '0;
  logic [31+AW:0] exp_q[$];

  instr_encoder #(.AW(AW), .BASE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_math(in_is_math), .in_imm(in_imm), .in_func(in_func), .in_class(in_class),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm_val(in_imm_val),
    .restart(restart), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: an output handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [31+AW:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word actual=%h/%0d expected=none", out_word, out_addr);
      end else begin
        e = exp_q.pop_front();
        if ({out_word, out_addr} !== e) begin
          bad++;
          $display("FAIL word_addr actual=%h/%0d expected=%h/%0d",
                   out_word, out_addr, e[31+AW:AW], e[AW-1:0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic m, input logic im, input logic [2:0] f, input logic [2:0] c,
                      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [16:0] iv, input logic [31:0] exp_word, input bit queued);
    int n = 0;
    in_valid = 1'b1; in_is_math = m; in_imm = im; in_func = f; in_class = c;
    in_rd = rd; in_rs = rs; in_rt = rt; in_imm_val = iv;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout actual=in_ready0 expected=in_ready1");
    end else if (queued) begin
      if (restart) model_addr = '0;
      exp_q.push_back({exp_word, model_addr});
      model_addr = model_addr + 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_word",  out_word,       32'h0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    @(posedge clk); #1;

    // addi rd3 rs1 imm5, then latency check, then xor
    send(1, 1, 3'd0, 3'd0, 5'd3, 5'd1, 5'd0, 17'd5, 32'h60C20005, 1);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    send(1, 0, 3'd6, 3'd0, 5'd2, 5'd4, 5'd6, 17'd0, 32'h18886000, 1);
    idle(3);

    // backpressure: two accepts fill the buffer, third stalls
    out_ready = 1'b0;
    send(1, 0, 3'd1, 3'd0, 5'd1, 5'd2, 5'd3, 17'd0, 32'h28443000, 1);
    send(0, 0, 3'd0, 3'd2, 5'd5, 5'd6, 5'd0, 17'h1ABCD, 32'h914DABCD, 1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(0, 0, 3'd0, 3'd7, 5'd0, 5'd0, 5'd0, 17'h00123, 32'hB8000123, 1);
      begin
        idle(3);
        chk("hold_out_word", out_word, 32'h28443000);
        chk("hold_out_addr", 32'(out_addr), 32'd2);
        out_ready = 1'b1;
      end
    join
    idle(4);

    // restart, then five ops wrapping 0,1,2,3,0
    restart = 1'b1; model_addr = '0;
    idle(1);
    restart = 1'b0;
    send(0, 0, 3'd0, 3'd6, 5'd0, 5'd9, 5'd0, 17'd0, 32'hB0120000, 1);
    send(1, 0, 3'd4, 3'd0, 5'd1, 5'd1, 5'd1, 17'd0, 32'h08421000, 1);
    send(0, 0, 3'd0, 3'd1, 5'd31, 5'd0, 5'd31, 17'd0, 32'h8FC1F000, 1);
    send(1, 1, 3'd5, 3'd0, 5'd0, 5'd31, 5'd0, 17'h1FFFF, 32'h503FFFFF, 1);
    send(0, 0, 3'd0, 3'd5, 5'd7, 5'd8, 5'd0, 17'h10000, 32'hA9D10000, 1);
    // push in the same cycle as restart gets BASE; next op gets BASE+1
    restart = 1'b1;
    send(1, 1, 3'd2, 3'd0, 5'd1, 5'd1, 5'd0, 17'd1, 32'h70420001, 1);
    restart = 1'b0;
    send(0, 0, 3'd0, 3'd4, 5'd0, 5'd0, 5'd0, 17'd0, 32'hA0000000, 1);
    idle(4);

    // illegal ops: func 7, then xori
    send(1, 0, 3'd7, 3'd0, 5'd1, 5'd2, 5'd3, 17'd9, 32'h0, !ERR_EN);
    chk("illegal_err", 32'(err), 32'(ERR_EN));
    idle(2);
    chk("illegal_no_output", 32'(out_valid), 32'd0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    err_clr = 1'b1;
    send(1, 1, 3'd6, 3'd0, 5'd4, 5'd4, 5'd4, 17'd4, 32'h0, !ERR_EN);
    err_clr = 1'b0;
    chk("err_clr_priority", 32'(err), 32'd0);
    // address must not have moved across dropped illegal ops
    send(1, 0, 3'd0, 3'd0, 5'd1, 5'd1, 5'd1, 17'd0, 32'h20421000, 1);
    idle(4);

    // reset with two words buffered
    out_ready = 1'b0;
    send(1, 0, 3'd0, 3'd0, 5'd1, 5'd1, 5'd1, 17'd0, 32'h20421000, 1);
    send(0, 0, 3'd0, 3'd3, 5'd2, 5'd3, 5'd0, 17'd4, 32'h98860004, 1);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_addr", 32'(out_addr), 32'd0);
    exp_q.delete();
    model_addr = '0;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    send(1, 1, 3'd3, 3'd0, 5'd4, 5'd5, 5'd0, 17'd7, 32'h790A0007, 1);
    idle(4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
